puf_apb_master: RTL and testbench

- APB4 initiator (requester) that drives the PUF APB slave ports on the peripheral bus.
- Accepts single read/write commands on a valid/ready command channel and runs the APB SETUP/ACCESS sequence, including wait states.
- Returns read data and error status on a valid/ready response channel.
- A watchdog aborts transfers whose PREADY never arrives.

---
 rtl/puf_apb_master_pkg.sv | 23 ++
 rtl/puf_apb_master_wdog.sv | 32 +++
 rtl/puf_apb_master.sv | 164 ++++++++++++++++
 tb/tb_puf_apb_master.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/puf_apb_master_pkg.sv
// Shared widths, FSM encodings and response record for the PUF APB initiator.
package puf_apb_master_pkg;

    localparam int APB_ADDR_WIDTH   = 32;
    localparam int APB_DATA_WIDTH   = 32;
    localparam int APB_STROBE_WIDTH = APB_DATA_WIDTH / 8;

    // Initiator FSM encodings (kept as plain constants for legacy tooling).
    localparam logic [1:0] APBM_IDLE   = 2'd0;
    localparam logic [1:0] APBM_SETUP  = 2'd1;
    localparam logic [1:0] APBM_ACCESS = 2'd2;
    localparam logic [1:0] APBM_RESP   = 2'd3;

    localparam int APBM_TIMEOUT_DEFAULT = 256;

    // Response fields travel together so they can be held as one register.
    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      slverr;
        logic                      timeout;
    } apbm_rsp_t;

endpackage

// File: rtl/puf_apb_master_wdog.sv
// Loadable saturating cycle counter; expire flags the last permitted cycle.
module puf_apb_master_wdog #(
    parameter int LIMIT = 256,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             inc,
    output logic             expire
);

    localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_reg;

    // Count up on request, stop at SAT so the value can never wrap back to 0.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (inc && (count_reg != SAT)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expire = (count_reg >= LAST);

endmodule

// File: rtl/puf_apb_master.sv
// APB4 initiator: one command in, SETUP/ACCESS on the bus, one response out.
module puf_apb_master
    import puf_apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APBM_TIMEOUT_DEFAULT
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [APB_STROBE_WIDTH-1:0] cmd_strb,
    input  logic [2:0]                  cmd_prot,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_slverr,
    output logic                        rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0]   paddr,
    output logic [APB_DATA_WIDTH-1:0]   pwdata,
    output logic [2:0]                  pprot,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [APB_STROBE_WIDTH-1:0] pstrb,
    input  logic                        pready,
    input  logic                        pslverr,
    input  logic [APB_DATA_WIDTH-1:0]   prdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]                  state_reg;
    logic [1:0]                  state_next;
    logic                        cmd_ready_reg;
    logic [APB_ADDR_WIDTH-1:0]   paddr_reg;
    logic [APB_DATA_WIDTH-1:0]   pwdata_reg;
    logic [2:0]                  pprot_reg;
    logic                        psel_reg;
    logic                        penable_reg;
    logic                        pwrite_reg;
    logic [APB_STROBE_WIDTH-1:0] pstrb_reg;
    logic                        rsp_valid_reg;
    apbm_rsp_t                   rsp_reg;
    logic [APB_STROBE_WIDTH-1:0] strb_gated;
    logic                        accept;
    logic                        wdog_expire;
    logic                        wdog_load;
    logic                        wdog_inc;

    // Reads must present all-zero strobes, so gate each byte lane by direction.
    generate
        for (genvar gi = 0; gi < APB_STROBE_WIDTH; gi++) begin : g_strb
            assign strb_gated[gi] = cmd_strb[gi] & cmd_write;
        end
    endgenerate

    assign accept    = (state_reg == APBM_IDLE) && cmd_valid && cmd_ready_reg;
    // Counter restarts once the response is consumed; it only advances while
    // the slave stalls and the abort point has not yet been reached.
    assign wdog_load = (state_reg == APBM_RESP) && rsp_ready;
    assign wdog_inc  = (state_reg == APBM_ACCESS) && !pready && !wdog_expire;

    puf_apb_master_wdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk        (pclk),
        .srst       (preset),
        .load       (wdog_load),
        .load_value ('0),
        .inc        (wdog_inc),
        .expire     (wdog_expire)
    );

    // Next-state selection; slave inputs only matter while in ACCESS.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            APBM_IDLE:   if (accept) state_next = APBM_SETUP;
            APBM_SETUP:  state_next = APBM_ACCESS;
            APBM_ACCESS: if (pready || wdog_expire) state_next = APBM_RESP;
            APBM_RESP:   if (rsp_ready) state_next = APBM_IDLE;
            default:     state_next = APBM_IDLE;
        endcase
    end

    // Registered bus and response outputs, updated per state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg     <= APBM_IDLE;
            cmd_ready_reg <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pprot_reg     <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            pstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                APBM_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (accept) begin
                        cmd_ready_reg <= 1'b0;
                        psel_reg      <= 1'b1;
                        paddr_reg     <= cmd_addr;
                        pwdata_reg    <= cmd_wdata;
                        pprot_reg     <= cmd_prot;
                        pwrite_reg    <= cmd_write;
                        pstrb_reg     <= strb_gated;
                    end
                end
                APBM_SETUP: begin
                    penable_reg <= 1'b1;
                end
                APBM_ACCESS: begin
                    // A late PREADY on the final permitted cycle still wins.
                    if (pready) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_reg.rdata   <= pwrite_reg ? '0 : prdata;
                        rsp_reg.slverr  <= pslverr;
                        rsp_reg.timeout <= 1'b0;
                    end else if (wdog_expire) begin
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_reg.rdata   <= '0;
                        rsp_reg.slverr  <= 1'b1;
                        rsp_reg.timeout <= 1'b1;
                    end
                end
                APBM_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign paddr       = paddr_reg;
    assign pwdata      = pwdata_reg;
    assign pprot       = pprot_reg;
    assign psel        = psel_reg;
    assign penable     = penable_reg;
    assign pwrite      = pwrite_reg;
    assign pstrb       = pstrb_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_reg.rdata;
    assign rsp_slverr  = rsp_reg.slverr;
    assign rsp_timeout = rsp_reg.timeout;

endmodule

// File: tb/tb_puf_apb_master.sv
// Directed plus randomized transactions against a transaction-level model.
module tb_puf_apb_master;

    localparam int TO = 8;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, rsp_timeout;
    logic [31:0] paddr, pwdata;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    puf_apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pprot       (pprot),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pstrb       (pstrb),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: the model predicts bus contents, ACCESS length,
    // latency and response; the slave side is played cycle by cycle.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic err, input logic [31:0] rdata, input int hold);
        logic        to;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_strb;
        logic [71:0] exp_bus;
        int          edges;
        int          acc;
        to        = (waits >= TO);
        exp_acc   = to ? TO : waits + 1;
        exp_rdata = (to || wr) ? 32'h0 : rdata;
        exp_err   = to ? 1'b1 : err;
        exp_strb  = wr ? strb : 4'h0;
        exp_bus   = {addr, wdata, wr, exp_strb, prot};

        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_strb = strb; cmd_prot = prot;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        @(posedge pclk); @(negedge pclk);
        // scramble the command bus: the APB outputs must not follow it
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
        chk("setup_sel_en", {psel, penable, cmd_ready}, 3'b100);
        chk("setup_bus", {paddr, pwdata, pwrite, pstrb, pprot}, exp_bus);
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;

        edges = 0;
        acc   = 0;
        while (rsp_valid !== 1'b1 && edges < 300) begin
            @(posedge pclk); edges++; @(negedge pclk);
            if (psel === 1'b1 && penable === 1'b1) begin
                chk("access_bus", {paddr, pwdata, pwrite, pstrb, pprot}, exp_bus);
                pready  = (acc == waits);
                pslverr = pready ? err : 1'($urandom);
                prdata  = pready ? rdata : $urandom;
                acc++;
            end else begin
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        chk("access_cycles", acc, exp_acc);
        chk("latency_edges", edges, exp_acc + 1);
        chk("resp_bus_idle", {psel, penable, cmd_ready}, 3'b000);
        chk("rsp_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, {exp_rdata, exp_err, to});

        cmd_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge pclk); @(negedge pclk);
            pready = 1'($urandom); prdata = $urandom;
            chk("hold_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout},
                {1'b1, exp_rdata, exp_err, to});
            chk("hold_busy", {cmd_ready, psel, penable}, 3'b000);
        end
        rsp_ready = 1'b1;
        @(posedge pclk); @(negedge pclk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("post_hs", {rsp_valid, cmd_ready, psel}, 3'b010);
        $display("txn wr=%0d addr=%08h waits=%0d err=%0d hold=%0d -> rdata=%08h slverr=%0d timeout=%0d",
                 wr, addr, waits, err, hold, rsp_rdata, rsp_slverr, rsp_timeout);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
        prdata = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset_ctrl", {psel, penable, rsp_valid, cmd_ready, pwrite}, 5'b0);
        chk("reset_bus", {paddr, pwdata, pstrb, pprot}, 0);
        chk("reset_rsp", {rsp_rdata, rsp_slverr, rsp_timeout}, 0);
        preset = 1'b0;
        @(posedge pclk); @(negedge pclk);
        chk("ready_after_reset", cmd_ready, 1);

        // directed cases
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 32'h0000_0014, 32'hCAFE_0001, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h3, 3'b001, 1, 1'b1, 32'hA5A5_5A5A, 2);
        run_txn(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'b000, 50, 1'b0, 32'hFFFF_FFFF, 0);
        run_txn(1'b1, 32'h0000_0028, 32'h0BAD_F00D, 4'h5, 3'b111, 2, 1'b0, 32'h0, 5);
        run_txn(1'b0, 32'h0000_002C, 32'h0, 4'hF, 3'b100, TO - 1, 1'b0, 32'h7777_0000, 0);
        run_txn(1'b1, 32'h0000_0030, 32'h1111_2222, 4'h9, 3'b011, TO, 1'b0, 32'h0, 1);

        // reset in the middle of an ACCESS phase
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_strb = 4'hF; cmd_prot = 3'b0;
        @(posedge pclk); @(negedge pclk);
        cmd_valid = 1'b0; pready = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        @(posedge pclk); @(negedge pclk);
        preset = 1'b0;
        chk("mid_reset", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            pready = 1'($urandom);
            @(posedge pclk); @(negedge pclk);
            chk("no_rsp_after_reset", {rsp_valid, psel}, 2'b00);
        end
        pready = 1'b0;
        $display("txn reset during ACCESS -> no response emitted");
        run_txn(1'b1, 32'h0000_0044, 32'h5555_AAAA, 4'hF, 3'b000, TO - 1, 1'b0, 32'h0, 0);

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, TO + 2), 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
